// File: rtl/aes128_enc_top.sv
// aes128_enc_top: iterative AES-128 encryption, one round per clock with on-the-fly key expansion
module aes128_enc_top (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    state_e fsm_q, fsm_d;
    logic [127:0] state_q, state_d, rk_q, rk_d, out_q, out_d;
    logic [3:0] round_q, round_d;
    logic valid_q, valid_d;
    logic [7:0] sb [16];
    logic [127:0] sr, mc, nk, rnd;
    logic [31:0] rot, t;
    logic [7:0] rcon;

    genvar i;
    for (i = 0; i < 16; i++) begin : g_sb
        assign sb[i] = sbox(state_q[127-8*i -: 8]);
        assign sr[127-8*i -: 8] = sb[4*(((i/4) + (i%4)) % 4) + (i%4)];
    end
    for (i = 0; i < 4; i++) begin : g_mc
        assign mc[127-32*i -: 32] = mix(sr[127-32*i -: 32]);
    end

    always_comb begin
        rcon = round_q == 4'd1 ? 8'h01 : round_q == 4'd2 ? 8'h02 : round_q == 4'd3 ? 8'h04 :
               round_q == 4'd4 ? 8'h08 : round_q == 4'd5 ? 8'h10 : round_q == 4'd6 ? 8'h20 :
               round_q == 4'd7 ? 8'h40 : round_q == 4'd8 ? 8'h80 : round_q == 4'd9 ? 8'h1b : 8'h36;
    end

    // Next round key: RotWord/SubWord/Rcon on the last word, then ripple the XOR across the words
    assign rot = {rk_q[23:0], rk_q[31:24]};
    assign t = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign nk[127:96] = rk_q[127:96] ^ t;
    assign nk[95:64] = rk_q[95:64] ^ nk[127:96];
    assign nk[63:32] = rk_q[63:32] ^ nk[95:64];
    assign nk[31:0] = rk_q[31:0] ^ nk[63:32];
    assign rnd = (round_q == 4'd10 ? sr : mc) ^ nk;

    always_comb begin
        fsm_d = fsm_q;
        state_d = state_q;
        rk_d = rk_q;
        round_d = round_q;
        out_d = out_q;
        valid_d = 1'b0;
        if (fsm_q == IDLE) begin
            if (AES_en) begin
                state_d = AES_data_in ^ AES_key_in;
                rk_d = AES_key_in;
                round_d = 4'd1;
                fsm_d = RUN;
            end
        end else begin
            state_d = rnd;
            rk_d = nk;
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
                out_d = rnd;
                valid_d = 1'b1;
                fsm_d = IDLE;
            end
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            fsm_q <= IDLE;
            state_q <= '0;
            rk_q <= '0;
            round_q <= '0;
            out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            state_q <= state_d;
            rk_q <= rk_d;
            round_q <= round_d;
            out_q <= out_d;
            valid_q <= valid_d;
        end
    end

    assign AES_data_out = out_q;
    assign AES_data_out_valid = valid_q;
endmodule

// File: tb/tb_aes128_enc_top.sv
// tb_aes128_enc_top: directed FIPS-197 vectors against aes128_enc_top, sampled on the falling edge
module tb_aes128_enc_top;
    logic clk = 1'b0;
    logic rst, en;
    logic [127:0] din, key, dout;
    logic vld;
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_enc_top dut (
        .AES_clk(clk),
        .AES_rst(rst),
        .AES_en(en),
        .AES_data_in(din),
        .AES_key_in(key),
        .AES_data_out(dout),
        .AES_data_out_valid(vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Capture one block, scramble inputs during RUN, check strobe timing and held data
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] c);
        en = 1'b1;
        key = k;
        din = p;
        @(negedge clk);
        en = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        din = {$urandom, $urandom, $urandom, $urandom};
        repeat (9) @(negedge clk);
        chk({tag, "_early"}, {127'b0, vld}, 128'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {127'b0, vld}, 128'd1);
        chk({tag, "_data"}, dout, c);
        @(negedge clk);
        chk({tag, "_drop"}, {127'b0, vld}, 128'd0);
        chk({tag, "_hold"}, dout, c);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        din = '0;
        key = '0;
        repeat (2) @(negedge clk);
        chk("rst_data", dout, 128'd0);
        chk("rst_valid", {127'b0, vld}, 128'd0);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("idle_valid", {127'b0, vld}, 128'd0);
            chk("idle_data", dout, 128'd0);
        end
        run_block("v1", K1, P1, C1);
        run_block("v2", K2, P2, C2);
        repeat (3) @(negedge clk);
        chk("v2_stable", dout, C2);
        run_block("v3", 128'd0, 128'd0, C3);

        en = 1'b1;
        key = K1;
        din = P1;
        @(negedge clk);
        key = K2;
        din = P2;
        repeat (9) @(negedge clk);
        chk("bb1_early", {127'b0, vld}, 128'd0);
        @(negedge clk);
        chk("bb1_valid", {127'b0, vld}, 128'd1);
        chk("bb1_data", dout, C1);
        @(negedge clk);
        key = '0;
        din = '0;
        chk("bb1_drop", {127'b0, vld}, 128'd0);
        repeat (9) @(negedge clk);
        chk("bb2_early", {127'b0, vld}, 128'd0);
        @(negedge clk);
        chk("bb2_valid", {127'b0, vld}, 128'd1);
        chk("bb2_data", dout, C2);
        @(negedge clk);
        key = K1;
        din = P1;
        repeat (10) @(negedge clk);
        chk("bb3_valid", {127'b0, vld}, 128'd1);
        chk("bb3_data", dout, C3);
        en = 1'b0;
        repeat (15) @(negedge clk);
        chk("bb_stop_valid", {127'b0, vld}, 128'd0);
        chk("bb_stop_data", dout, C3);

        en = 1'b1;
        key = K2;
        din = P2;
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_data", dout, 128'd0);
        chk("abort_valid", {127'b0, vld}, 128'd0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("abort_quiet", {127'b0, vld}, 128'd0);
            chk("abort_zero", dout, 128'd0);
        end
        run_block("fresh", K2, P2, C2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
